axi4_lite_slave_regs: RTL



---
 rtl/axi4_lite_slave_regs_pkg.sv | 45 ++++
 rtl/axi4_lite_regfile.sv | 64 ++++++
 rtl/axi4_lite_slave_regs.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_slave_regs_pkg.sv
// Shared types, response codes and address-decode helpers for the AXI4-Lite register slave.
package axi4_lite_slave_regs_pkg;

    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned WORD_ADDR_W = ADDR_W - 2;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned STRB_W      = DATA_W / 8;
    localparam int unsigned REG_IDX_W   = 3;
    localparam int unsigned RESP_W      = 2;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_ADDR_OK = 2'd1,
        WR_DATA_OK = 2'd2,
        WR_RESP    = 2'd3
    } wr_state_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_DATA = 1'b1
    } rd_state_t;

    // Captured write request; the byte offset bits are dropped at capture.
    typedef struct packed {
        logic [WORD_ADDR_W-1:0] word_addr;
        logic [DATA_W-1:0]      data;
        logic [STRB_W-1:0]      strb;
    } wr_req_t;

    // Register index taken from byte-address bits [4:2].
    function automatic logic [REG_IDX_W-1:0] word_index(input logic [WORD_ADDR_W-1:0] word_addr);
        return word_addr[REG_IDX_W-1:0];
    endfunction

    // True when upper address bits are clear and the index names an existing register.
    function automatic logic word_in_range(input logic [WORD_ADDR_W-1:0] word_addr,
                                           input int unsigned           nregs);
        return (word_addr[WORD_ADDR_W-1:REG_IDX_W] == '0) &&
               (32'(word_addr[REG_IDX_W-1:0]) < nregs);
    endfunction

endpackage

// File: rtl/axi4_lite_regfile.sv
// Byte-strobed register array with a read mux; the top slot reflects the live status input.
module axi4_lite_regfile
    import axi4_lite_slave_regs_pkg::*;
#(
    parameter int unsigned data_width = 32,
    parameter int unsigned num_regs   = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           i_wr_en,
    input  logic [REG_IDX_W-1:0]           i_wr_idx,
    input  logic [data_width-1:0]          i_wr_data,
    input  logic [data_width/8-1:0]        i_wr_strb,
    input  logic [REG_IDX_W-1:0]           i_rd_idx,
    input  logic [data_width-1:0]          i_status,
    output logic [data_width-1:0]          o_rd_data_c,
    output logic [num_regs*data_width-1:0] o_reg_image_c
);

    localparam int unsigned NUM_RW = num_regs - 1;
    localparam int unsigned NBYTES = data_width / 8;

    logic [data_width-1:0] r_regs [NUM_RW];

    // Byte-lane update of the writable registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_RW; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_RW; i++) begin
                for (int k = 0; k < NBYTES; k++) begin
                    if (i_wr_en && (i_wr_idx == REG_IDX_W'(i)) && i_wr_strb[k]) begin
                        r_regs[i][8*k +: 8] <= i_wr_data[8*k +: 8];
                    end
                end
            end
        end
    end

    // Read mux; unmapped indices read as zero.
    always_comb begin
        o_rd_data_c = '0;
        for (int i = 0; i < NUM_RW; i++) begin
            if (i_rd_idx == REG_IDX_W'(i)) begin
                o_rd_data_c = r_regs[i];
            end
        end
        if (i_rd_idx == REG_IDX_W'(num_regs - 1)) begin
            o_rd_data_c = i_status;
        end
    end

    // Flat image of all registers with status in the top slot.
    always_comb begin
        o_reg_image_c = '0;
        for (int i = 0; i < NUM_RW; i++) begin
            o_reg_image_c[data_width*i +: data_width] = r_regs[i];
        end
        o_reg_image_c[data_width*(num_regs-1) +: data_width] = i_status;
    end

endmodule

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave: independent write and read FSMs in front of a small register file.
module axi4_lite_slave_regs
    import axi4_lite_slave_regs_pkg::*;
#(
    parameter int unsigned data_width = 32,
    parameter int unsigned num_regs   = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           AWvalid,
    output logic                           AWready,
    input  logic [ADDR_W-1:0]              AWaddr,
    input  logic                           Wvalid,
    output logic                           Wready,
    input  logic [data_width-1:0]          Wdata,
    input  logic [data_width/8-1:0]        Wstrb,
    output logic                           Bvalid,
    input  logic                           Bready,
    output logic [RESP_W-1:0]              Bresp,
    input  logic                           ARvalid,
    output logic                           ARready,
    input  logic [ADDR_W-1:0]              ARaddr,
    output logic                           Rvalid,
    input  logic                           Rready,
    output logic [data_width-1:0]          Rdata,
    output logic [RESP_W-1:0]              Rresp,
    input  logic [data_width-1:0]          status_in,
    output logic [num_regs*data_width-1:0] reg_out,
    output logic [num_regs-1:0]            wr_pulse
);

    wr_state_t               r_wr_state, w_wr_state_nxt;
    rd_state_t               r_rd_state, w_rd_state_nxt;
    wr_req_t                 r_wr_req, w_wr_req_nxt;
    logic                    r_awready, w_awready_nxt;
    logic                    r_wready, w_wready_nxt;
    logic                    r_bvalid, w_bvalid_nxt;
    logic [RESP_W-1:0]       r_bresp, w_bresp_nxt;
    logic                    r_arready, w_arready_nxt;
    logic                    r_rvalid, w_rvalid_nxt;
    logic [data_width-1:0]   r_rdata, w_rdata_nxt;
    logic [RESP_W-1:0]       r_rresp, w_rresp_nxt;
    logic [num_regs-1:0]     r_wr_pulse, w_wr_pulse_nxt;
    logic                    w_commit;
    logic                    w_wr_ok;
    logic                    w_rd_in_range;
    logic [data_width-1:0]   w_rd_data;
    logic [WORD_ADDR_W-1:0]  w_ar_word;
    logic                    w_unused_addr_lsbs;

    wire w_aw_hs = AWvalid && r_awready;
    wire w_w_hs  = Wvalid  && r_wready;
    wire w_b_hs  = r_bvalid && Bready;
    wire w_ar_hs = ARvalid && r_arready;
    wire w_r_hs  = r_rvalid && Rready;

    assign w_ar_word          = ARaddr[ADDR_W-1:2];
    assign w_rd_in_range      = word_in_range(w_ar_word, num_regs);
    assign w_unused_addr_lsbs = ^{AWaddr[1:0], ARaddr[1:0]};

    // Write FSM: capture address/data, commit on entry to WR_RESP, hold response until Bready.
    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_wr_req_nxt   = r_wr_req;
        w_awready_nxt  = r_awready;
        w_wready_nxt   = r_wready;
        w_bvalid_nxt   = r_bvalid;
        w_bresp_nxt    = r_bresp;
        w_commit       = 1'b0;

        if (w_aw_hs) begin
            w_wr_req_nxt.word_addr = AWaddr[ADDR_W-1:2];
        end
        if (w_w_hs) begin
            w_wr_req_nxt.data = Wdata;
            w_wr_req_nxt.strb = Wstrb;
        end

        w_wr_ok = word_in_range(w_wr_req_nxt.word_addr, num_regs) &&
                  (word_index(w_wr_req_nxt.word_addr) != REG_IDX_W'(num_regs - 1));

        case (r_wr_state)
            WR_IDLE: begin
                w_awready_nxt = 1'b1;
                w_wready_nxt  = 1'b1;
                if (w_aw_hs && w_w_hs) begin
                    w_commit = 1'b1;
                end else if (w_aw_hs) begin
                    w_wr_state_nxt = WR_ADDR_OK;
                    w_awready_nxt  = 1'b0;
                end else if (w_w_hs) begin
                    w_wr_state_nxt = WR_DATA_OK;
                    w_wready_nxt   = 1'b0;
                end
            end
            WR_ADDR_OK: begin
                if (w_w_hs) begin
                    w_commit = 1'b1;
                end
            end
            WR_DATA_OK: begin
                if (w_aw_hs) begin
                    w_commit = 1'b1;
                end
            end
            WR_RESP: begin
                if (w_b_hs) begin
                    w_wr_state_nxt = WR_IDLE;
                    w_bvalid_nxt   = 1'b0;
                    w_awready_nxt  = 1'b1;
                    w_wready_nxt   = 1'b1;
                end
            end
            default: begin
                w_wr_state_nxt = WR_IDLE;
            end
        endcase

        if (w_commit) begin
            w_wr_state_nxt = WR_RESP;
            w_awready_nxt  = 1'b0;
            w_wready_nxt   = 1'b0;
            w_bvalid_nxt   = 1'b1;
            w_bresp_nxt    = w_wr_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // One-cycle strobe for the register actually written.
    always_comb begin
        w_wr_pulse_nxt = '0;
        for (int i = 0; i < num_regs; i++) begin
            if (w_commit && w_wr_ok && (w_wr_req_nxt.strb != '0) &&
                (word_index(w_wr_req_nxt.word_addr) == REG_IDX_W'(i))) begin
                w_wr_pulse_nxt[i] = 1'b1;
            end
        end
    end

    // Read FSM: register data and response on AR handshake, hold until Rready.
    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_arready_nxt  = r_arready;
        w_rvalid_nxt   = r_rvalid;
        w_rdata_nxt    = r_rdata;
        w_rresp_nxt    = r_rresp;

        case (r_rd_state)
            RD_IDLE: begin
                w_arready_nxt = 1'b1;
                if (w_ar_hs) begin
                    w_rd_state_nxt = RD_DATA;
                    w_arready_nxt  = 1'b0;
                    w_rvalid_nxt   = 1'b1;
                    w_rdata_nxt    = w_rd_in_range ? w_rd_data : '0;
                    w_rresp_nxt    = w_rd_in_range ? RESP_OKAY : RESP_SLVERR;
                end
            end
            RD_DATA: begin
                if (w_r_hs) begin
                    w_rd_state_nxt = RD_IDLE;
                    w_rvalid_nxt   = 1'b0;
                    w_arready_nxt  = 1'b1;
                end
            end
            default: begin
                w_rd_state_nxt = RD_IDLE;
            end
        endcase
    end

    // State and output registers for both channels.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_state <= WR_IDLE;
            r_rd_state <= RD_IDLE;
            r_wr_req   <= '0;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= RESP_OKAY;
            r_wr_pulse <= '0;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_rd_state <= w_rd_state_nxt;
            r_wr_req   <= w_wr_req_nxt;
            r_awready  <= w_awready_nxt;
            r_wready   <= w_wready_nxt;
            r_bvalid   <= w_bvalid_nxt;
            r_bresp    <= w_bresp_nxt;
            r_arready  <= w_arready_nxt;
            r_rvalid   <= w_rvalid_nxt;
            r_rdata    <= w_rdata_nxt;
            r_rresp    <= w_rresp_nxt;
            r_wr_pulse <= w_wr_pulse_nxt;
        end
    end

    axi4_lite_regfile #(
        .data_width (data_width),
        .num_regs   (num_regs)
    ) u_regfile (
        .clk           (clk),
        .reset         (reset),
        .i_wr_en       (w_commit && w_wr_ok),
        .i_wr_idx      (word_index(w_wr_req_nxt.word_addr)),
        .i_wr_data     (w_wr_req_nxt.data),
        .i_wr_strb     (w_wr_req_nxt.strb),
        .i_rd_idx      (word_index(w_ar_word)),
        .i_status      (status_in),
        .o_rd_data_c   (w_rd_data),
        .o_reg_image_c (reg_out)
    );

    assign AWready  = r_awready;
    assign Wready   = r_wready;
    assign Bvalid   = r_bvalid;
    assign Bresp    = r_bresp;
    assign ARready  = r_arready;
    assign Rvalid   = r_rvalid;
    assign Rdata    = r_rdata;
    assign Rresp    = r_rresp;
    assign wr_pulse = r_wr_pulse;

endmodule
